uart_tx_frame: RTL and testbench

//  Parametrised UART transmitter: serialises one word per frame as start bit, DATA_WIDTH data bits
//  (LSB first), optional parity bit and 1-2 stop bits, each bit held CLKS_PER_BIT clocks.

---
 rtl/uart_tx_frame_pkg.sv | 27 ++
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_tx_frame.sv | 133 +++++++++++++
 tb/tb_uart_tx_frame.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_frame_pkg.sv
// Shared definitions for the UART transmitter.
// Parity modes, default word width and FSM states.
package uart_tx_frame_pkg;

  localparam int UART_DATA_WIDTH = 8;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Upper bits of d must be zero; they do not change the XOR.
  function automatic logic par_bit(
    input int         mode,
    input logic [8:0] d
  );
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART.
// Pulses bit_end in the last clock of each bit period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == '0);

  // Down-counter: reload on restart or when a bit period ends.
  always_ff @(posedge clk_i) begin
    if (rst_i || restart || bit_end) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, data LSB first, optional parity, stop.
// Ready/valid input, registered glitch-free serial output.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_i_v,
  output logic                  data_i_rdy,
  output logic                  tx_o,
  output logic                  busy_o
);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9 ||
      CLKS_PER_BIT < 2 ||
      PARITY < PAR_NONE || PARITY > PAR_EVEN ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_tx_frame: illegal parameter set");
  end

  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_D = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_S = BW'(STOP_BITS - 1);
  localparam bit HAS_PAR = (PARITY != PAR_NONE);

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0]         bcnt, bcnt_n;
  logic                  par, par_n;
  logic                  tx, tx_n;
  logic                  rdy, accept;
  logic                  restart, bit_end;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .restart(restart),
    .bit_end(bit_end)
  );

  assign data_i_rdy = rdy;
  assign tx_o       = tx;
  assign busy_o     = (state != S_IDLE);

  // Next state, shift/count updates and the next serial bit.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bcnt_n  = bcnt;
    par_n   = par;
    restart = 1'b0;
    rdy     = 1'b0;
    unique case (state)
      S_IDLE: rdy = 1'b1;
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          bcnt_n  = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_n = shreg >> 1;
          if (bcnt == LAST_D) begin
            state_n = HAS_PAR ? S_PARITY : S_STOP;
            bcnt_n  = '0;
          end else begin
            bcnt_n = bcnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          bcnt_n  = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bcnt == LAST_S) begin
            rdy     = 1'b1;
            state_n = S_IDLE;
          end else begin
            bcnt_n = bcnt + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (rst_i) begin
      rdy = 1'b0;
    end
    accept = rdy && data_i_v;
    if (accept) begin
      state_n = S_START;
      shreg_n = data_i;
      par_n   = par_bit(PARITY, 9'(data_i));
      restart = 1'b1;
    end
    unique case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shreg_n[0];
      S_PARITY: tx_n = par_n;
      default:  tx_n = 1'b1;
    endcase
  end

  // State, datapath and output line registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      shreg <= '0;
      bcnt  <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      bcnt  <= bcnt_n;
      par   <= par_n;
      tx    <= tx_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: five parameter sets on one clock,
// table vectors, random words and hand-written corner sequences.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] vld, rdy, tx, busy;
  logic [8:0] din [5];

  int dw_c  [5] = '{8, 8, 8, 8, 5};
  int cpb_c [5] = '{4, 4, 4, 4, 2};
  int par_c [5] = '{0, 2, 1, 0, 0};
  int sb_c  [5] = '{1, 1, 1, 2, 1};

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4),
    .PARITY(0), .STOP_BITS(1)) u_n1 (
    .clk_i(clk), .rst_i(rst), .data_i(din[0][7:0]),
    .data_i_v(vld[0]), .data_i_rdy(rdy[0]),
    .tx_o(tx[0]), .busy_o(busy[0]));

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4),
    .PARITY(2), .STOP_BITS(1)) u_e1 (
    .clk_i(clk), .rst_i(rst), .data_i(din[1][7:0]),
    .data_i_v(vld[1]), .data_i_rdy(rdy[1]),
    .tx_o(tx[1]), .busy_o(busy[1]));

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4),
    .PARITY(1), .STOP_BITS(1)) u_o1 (
    .clk_i(clk), .rst_i(rst), .data_i(din[2][7:0]),
    .data_i_v(vld[2]), .data_i_rdy(rdy[2]),
    .tx_o(tx[2]), .busy_o(busy[2]));

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4),
    .PARITY(0), .STOP_BITS(2)) u_n2 (
    .clk_i(clk), .rst_i(rst), .data_i(din[3][7:0]),
    .data_i_v(vld[3]), .data_i_rdy(rdy[3]),
    .tx_o(tx[3]), .busy_o(busy[3]));

  uart_tx_frame #(.DATA_WIDTH(5), .CLKS_PER_BIT(2),
    .PARITY(0), .STOP_BITS(1)) u_5n1 (
    .clk_i(clk), .rst_i(rst), .data_i(din[4][4:0]),
    .data_i_v(vld[4]), .data_i_rdy(rdy[4]),
    .tx_o(tx[4]), .busy_o(busy[4]));

  // Reference model: frame length and line value per cycle.
  function automatic int flen(input int k);
    return cpb_c[k] * (1 + dw_c[k] + (par_c[k] != 0 ? 1 : 0) + sb_c[k]);
  endfunction

  function automatic logic mpar(input int k, input logic [8:0] w);
    logic [8:0] m;
    m = w & 9'((1 << dw_c[k]) - 1);
    return (par_c[k] == 1) ? ~^m : ^m;
  endfunction

  function automatic logic exp_tx(input int k, input logic [8:0] w,
                                  input int c);
    int b;
    b = c / cpb_c[k];
    if (b == 0) return 1'b0;
    if (b <= dw_c[k]) return w[b-1];
    if (par_c[k] != 0 && b == dw_c[k] + 1) return mpar(k, w);
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Line must sit idle for n cycles: tx=1, busy=0, rdy=1.
  task automatic idle_chk(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("idle k%0d i%0d", k, i),
          32'({tx[k], busy[k], rdy[k]}), 32'b101);
    end
  endtask

  // Send one word (called at a negedge), check every frame cycle,
  // the measured busy length and the sampled parity bit.
  // inj >= 0 raises valid with another word mid-frame for 3 cycles.
  task automatic send_chk(input int k, input logic [8:0] w,
                          input int len_exp, input logic par_exp,
                          input int inj);
    int   len, nb;
    logic ps;
    len = flen(k);
    nb  = 0;
    ps  = 1'bx;
    chk($sformatf("rdy_pre k%0d", k), 32'(rdy[k]), 32'd1);
    din[k] = w;
    vld[k] = 1'b1;
    @(posedge clk);
    #1;
    vld[k] = 1'b0;
    din[k] = '0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (inj >= 0 && c == inj) begin
        din[k] = 9'h1FF;
        vld[k] = 1'b1;
      end
      if (inj >= 0 && c == inj + 3) vld[k] = 1'b0;
      chk($sformatf("frame k%0d w%0h c%0d", k, w, c),
          32'({tx[k], busy[k], rdy[k]}),
          32'({exp_tx(k, w, c), 1'b1, c == len - 1}));
      if (busy[k]) nb++;
      if (c == (dw_c[k] + 1) * cpb_c[k] + cpb_c[k] / 2) ps = tx[k];
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("post k%0d i%0d", k, i),
          32'({tx[k], busy[k], rdy[k]}), 32'b101);
      if (busy[k]) nb++;
    end
    chk($sformatf("busy_len k%0d", k), 32'(nb), 32'(len_exp));
    if (par_c[k] != 0)
      chk($sformatf("parity k%0d w%0h", k, w), 32'(ps), 32'(par_exp));
  endtask

  typedef struct {
    int         k;
    logic [8:0] w;
    int         len;
    logic       par;
    int         inj;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{k: 0, w: 9'h0A5, len: 40, par: 1'b0, inj: -1};
    tbl[1] = '{k: 1, w: 9'h0A5, len: 44, par: 1'b0, inj: -1};
    tbl[2] = '{k: 2, w: 9'h0A5, len: 44, par: 1'b1, inj: -1};
    tbl[3] = '{k: 1, w: 9'h001, len: 44, par: 1'b1, inj: -1};
    tbl[4] = '{k: 4, w: 9'h01F, len: 14, par: 1'b0, inj: -1};
    tbl[5] = '{k: 0, w: 9'h081, len: 40, par: 1'b0, inj: 10};

    rst = 1'b1;
    vld = '0;
    for (int k = 0; k < 5; k++) din[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(rdy), 32'h0);
    chk("rst_tx", 32'(tx), 32'h1F);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 32'(rdy), 32'h1F);
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      send_chk(tbl[i].k, tbl[i].w, tbl[i].len, tbl[i].par, tbl[i].inj);

    // Back-to-back frames with valid held high, two stop bits.
    begin
      int len;
      len = flen(3);
      din[3] = 9'h055;
      vld[3] = 1'b1;
      @(posedge clk);
      #1;
      din[3] = 9'h00F;
      for (int c = 0; c < 2 * len; c++) begin
        @(negedge clk);
        chk($sformatf("b2b c%0d", c),
            32'({tx[3], busy[3], rdy[3]}),
            32'({(c < len) ? exp_tx(3, 9'h055, c)
                           : exp_tx(3, 9'h00F, c - len),
                 1'b1, (c == len - 1) || (c == 2 * len - 1)}));
        if (c == len) vld[3] = 1'b0;
      end
      idle_chk(3, 2 * len);
    end

    // Reset during data bit 3 aborts the frame.
    din[0] = 9'h03C;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre_abort_busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx", 32'(tx[0]), 32'd1);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_rdy", 32'(rdy[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_rdy_after", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    send_chk(0, 9'h0C3, 40, 1'b0, -1);

    // Random words on random configurations.
    for (int i = 0; i < 25; i++) begin
      int         k;
      logic [8:0] w;
      k = $urandom_range(0, 4);
      w = 9'($urandom) & 9'((1 << dw_c[k]) - 1);
      send_chk(k, w, flen(k), mpar(k, w), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
